serial_rx: RTL and testbench

Single-wire serial frame receiver for the lab02 serial link, the reading end of the link that serial transmitters drive one bit at a time. It watches one idle-high input line, detects a start bit, samples data bits mid-bit LSB first, checks the stop bit, and presents the assembled word on a parallel output with a one-cycle valid strobe. It sits between a bit-level line driver (bench stimulus or a transmitter module) and any consumer of parallel bytes.

---
 rtl/serial_rx.sv | 151 +++++++++++++++
 tb/tb_serial_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// Single-wire serial frame receiver: start bit, DATA_BITS data bits LSB first,
// optional even-parity bit (`SERIAL_RX_PARITY_EN`), one stop bit.
module serial_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   perr;

`ifdef SERIAL_RX_PARITY_EN
  logic perr_q, perr_d;
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    out_d       = out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    perr_d      = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!in) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          // A start bit that has vanished by mid-bit is a glitch, not a frame
          if (!in) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          shreg_d                = shreg_q >> 1;
          shreg_d[DATA_BITS-1]   = in;
          cnt_d                  = '0;
          idx_d                  = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          perr_d  = (in != ^shreg_q);
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          if (in && !perr) begin
            out_d   = shreg_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx with default parameters; frames carry a parity
// bit when SERIAL_RX_PARITY_EN is defined.
module tb_serial_rx;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int HALF = CPB / 2;
`ifdef SERIAL_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int STOP_LAT = HALF + (DB + 1 + P) * CPB;
  localparam int FRAME_LEN = (DB + 2 + P) * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_r = 1'b1;
  logic [DB-1:0] out_w;
  logic          valid_w, frame_err_w, busy_w;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_valid, n_ferr, n_busy, n_both;
  int valid_cyc [4];
  logic [DB-1:0] valid_out [4];
  int e0;

  serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_r),
    .out       (out_w),
    .valid     (valid_w),
    .frame_err (frame_err_w),
    .busy      (busy_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_w) begin
      if (n_valid < 4) begin
        valid_cyc[n_valid] = cyc;
        valid_out[n_valid] = out_w;
      end
      n_valid = n_valid + 1;
    end
    if (frame_err_w) n_ferr = n_ferr + 1;
    if (busy_w) n_busy = n_busy + 1;
    if (valid_w && frame_err_w) n_both = n_both + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_valid = 0;
    n_ferr  = 0;
    n_busy  = 0;
    n_both  = 0;
  endtask

  task automatic send_bit(input logic b);
    in_r = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit, input logic par_flip);
    e0 = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(data[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^data) ^ par_flip);
`endif
    send_bit(stop_bit);
    in_r = 1'b1;
  endtask

  initial begin
    clr_counts();
    // reset and long idle
    reset = 1'b1;
    in_r  = 1'b1;
    tick(3);
    reset = 1'b0;
    check_eq("rst_out", 32'(out_w), 32'h0);
    check_eq("rst_valid", 32'(valid_w), 32'h0);
    check_eq("rst_ferr", 32'(frame_err_w), 32'h0);
    check_eq("rst_busy", 32'(busy_w), 32'h0);
    clr_counts();
    tick(100);
    check_eq("idle_valid", 32'(n_valid), 32'd0);
    check_eq("idle_ferr", 32'(n_ferr), 32'd0);
    check_eq("idle_busy", 32'(n_busy), 32'd0);
    check_eq("idle_out", 32'(out_w), 32'h0);
    $display("txn idle: 100 cycles done");

    // good frame 0xA5
    clr_counts();
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(6);
    check_eq("a5_nvalid", 32'(n_valid), 32'd1);
    check_eq("a5_latency", 32'(valid_cyc[0] - e0), 32'(STOP_LAT));
    check_eq("a5_out", 32'(out_w), 32'hA5);
    check_eq("a5_ferr", 32'(n_ferr), 32'd0);
    $display("txn frame 0xA5: out=0x%0h", out_w);

    // bad stop bit
    clr_counts();
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(10);
    check_eq("3c_ferr", 32'(n_ferr), 32'd1);
    check_eq("3c_nvalid", 32'(n_valid), 32'd0);
    check_eq("3c_out_held", 32'(out_w), 32'hA5);
    $display("txn frame 0x3C bad stop: out=0x%0h", out_w);

    // one-cycle start glitch
    clr_counts();
    in_r = 1'b0;
    tick(1);
    in_r = 1'b1;
    tick(10);
    check_eq("glitch_busy", 32'(n_busy), 32'(HALF));
    check_eq("glitch_valid", 32'(n_valid), 32'd0);
    check_eq("glitch_ferr", 32'(n_ferr), 32'd0);
    $display("txn glitch: busy cycles=%0d", n_busy);

    // back-to-back frames
    clr_counts();
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    tick(6);
    check_eq("b2b_nvalid", 32'(n_valid), 32'd2);
    check_eq("b2b_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'(FRAME_LEN));
    check_eq("b2b_out0", 32'(valid_out[0]), 32'h01);
    check_eq("b2b_out1", 32'(valid_out[1]), 32'hFF);
    $display("txn back-to-back: 0x%0h then 0x%0h", valid_out[0], valid_out[1]);

    // reset in the middle of data bit 4
    clr_counts();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    in_r = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_eq("midrst_busy", 32'(busy_w), 32'h0);
    check_eq("midrst_out", 32'(out_w), 32'h0);
    in_r = 1'b1;
    tick(10);
    check_eq("midrst_valid", 32'(n_valid), 32'd0);
    check_eq("midrst_ferr", 32'(n_ferr), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(6);
    check_eq("5a_nvalid", 32'(n_valid), 32'd1);
    check_eq("5a_out", 32'(out_w), 32'h5A);
    $display("txn reset mid-frame then 0x5A: out=0x%0h", out_w);

`ifdef SERIAL_RX_PARITY_EN
    clr_counts();
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(6);
    check_eq("par_ferr", 32'(n_ferr), 32'd1);
    check_eq("par_nvalid", 32'(n_valid), 32'd0);
    check_eq("par_out_held", 32'(out_w), 32'h5A);
    $display("txn 0x5A wrong parity: ferr pulses=%0d", n_ferr);
`endif

    check_eq("never_both", 32'(n_both), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
